// File: rtl/sram_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_bus_arbiter_pkg
// Shared definitions for the SRAM bus arbiter slice:
//   - arb_state_t : bus-ownership state encoding
//   - ADDR_W_DEF / DATA_W_DEF : default SRAM/SNES address and data widths
//   - GUARD_W     : width of the ownership-change guard counter
//   - guard_inc() : saturating increment for the guard counter
// -----------------------------------------------------------------------------
package sram_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        AVR_OWN  = 2'd0,
        TO_SNES  = 2'd1,
        SNES_OWN = 2'd2,
        TO_AVR   = 2'd3
    } arb_state_t;

    localparam int ADDR_W_DEF = 21;
    localparam int DATA_W_DEF = 8;
    localparam int GUARD_W    = 4;

    // Saturates at all-ones so an over-long count can never wrap back to an
    // early exit value.
    function automatic logic [GUARD_W-1:0] guard_inc(input logic [GUARD_W-1:0] cnt);
        return (cnt == {GUARD_W{1'b1}}) ? cnt : cnt + {{(GUARD_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_bus_arbiter_if
// Request/response bundle between the two bus masters (AVR loader path and
// SNES cartridge bus) and the SRAM bus arbiter.
//   avr_snes_mode          : 1 = request SNES ownership, 0 = request AVR ownership
//   avr_addr/oe_n/we_n/wdata: AVR access (strobes active-low)
//   avr_rdata              : registered SRAM read data back to the AVR
//   snes_addr/rd_n/cs_n    : SNES ROM read access (strobes active-low)
//   snes_data              : registered read data back to the SNES
//   mode_ack               : 1 = SNES owns the bus, 0 = AVR owns the bus
//   busy                   : ownership change in progress
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface sram_bus_arbiter_if
    import sram_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              avr_snes_mode;
    logic [ADDR_W-1:0] avr_addr;
    logic              avr_oe_n;
    logic              avr_we_n;
    logic [DATA_W-1:0] avr_wdata;
    logic [DATA_W-1:0] avr_rdata;
    logic [ADDR_W-1:0] snes_addr;
    logic              snes_rd_n;
    logic              snes_cs_n;
    logic [DATA_W-1:0] snes_data;
    logic              mode_ack;
    logic              busy;

    modport master (
        output avr_snes_mode, avr_addr, avr_oe_n, avr_we_n, avr_wdata,
        output snes_addr, snes_rd_n, snes_cs_n,
        input  avr_rdata, snes_data, mode_ack, busy
    );

    modport slave (
        input  avr_snes_mode, avr_addr, avr_oe_n, avr_we_n, avr_wdata,
        input  snes_addr, snes_rd_n, snes_cs_n,
        output avr_rdata, snes_data, mode_ack, busy
    );

endinterface

// File: rtl/sram_bus_arbiter_sync2.sv
// -----------------------------------------------------------------------------
// sram_bus_arbiter_sync2
// Two-flop synchronizer for the avr_snes_mode request, asynchronous
// active-high reset to 0.
//   clk   : destination clock
//   reset : asynchronous active-high reset
//   d     : asynchronous input
//   q     : synchronized output (2 clk latency)
// Only built when MODE_SYNC_EN is defined, which is also the only build in
// which the arbiter instantiates it.
// -----------------------------------------------------------------------------
`ifdef MODE_SYNC_EN
module sram_bus_arbiter_sync2 #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] stage_reg;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) stage_reg[gi] <= 1'b0;
                    else       stage_reg[gi] <= d;
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) stage_reg[gi] <= 1'b0;
                    else       stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign q = stage_reg[STAGES-1];
endmodule
`endif

// File: rtl/sram_bus_arbiter.sv
// -----------------------------------------------------------------------------
// sram_bus_arbiter
// Owns the SRAM pins and hands them between the AVR loader path and the SNES
// cartridge bus (ROM reads only). Every ownership change passes through a
// guard interval of GUARD_CYCLES clk with all SRAM strobes deasserted, so the
// two masters never drive the SRAM at the same time.
//
// Ports:
//   clk        : system clock
//   reset      : asynchronous active-high reset
//   bus        : sram_bus_arbiter_if.slave (AVR/SNES requests and responses)
//   sram_addr  : registered SRAM address
//   sram_data  : SRAM data bus, driven only during AVR writes
//   sram_oe_n, sram_we_n, sram_ce_n : registered SRAM strobes, active-low
//
// Parameters: ADDR_W, DATA_W, GUARD_CYCLES (legal 1..15).
// Build option: define MODE_SYNC_EN to pass avr_snes_mode through a 2-flop
// synchronizer (2 clk extra request latency); otherwise it is used directly.
// -----------------------------------------------------------------------------
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int GUARD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    sram_bus_arbiter_if.slave bus,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ce_n
);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES);

    arb_state_t         state_reg;
    logic [GUARD_W-1:0] guard_cnt_reg;
    logic [GUARD_W-1:0] guard_cnt_next;
    logic               mode_ack_reg;
    logic               busy_reg;
    logic [ADDR_W-1:0]  sram_addr_reg;
    logic               sram_oe_n_reg;
    logic               sram_we_n_reg;
    logic               sram_ce_n_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic [DATA_W-1:0]  avr_rdata_reg;
    logic [DATA_W-1:0]  snes_data_reg;
    logic               sram_data_oe;
    logic               mode_req;

`ifdef MODE_SYNC_EN
    sram_bus_arbiter_sync2 #(.STAGES(2)) u_mode_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.avr_snes_mode),
        .q     (mode_req)
    );
`else
    assign mode_req = bus.avr_snes_mode;
`endif

    assign guard_cnt_next = guard_inc(guard_cnt_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= AVR_OWN;
            guard_cnt_reg <= '0;
            mode_ack_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            sram_addr_reg <= '0;
            sram_oe_n_reg <= 1'b1;
            sram_we_n_reg <= 1'b1;
            sram_ce_n_reg <= 1'b1;
            wdata_reg     <= '0;
            avr_rdata_reg <= '0;
            snes_data_reg <= '0;
        end else begin
            case (state_reg)
                AVR_OWN: begin
                    sram_addr_reg <= bus.avr_addr;
                    sram_we_n_reg <= bus.avr_we_n;
                    // A simultaneous read+write request is treated as a write:
                    // keep OE off so the SRAM never fights our data driver.
                    sram_oe_n_reg <= bus.avr_oe_n | ~bus.avr_we_n;
                    sram_ce_n_reg <= bus.avr_oe_n & bus.avr_we_n;
                    wdata_reg     <= bus.avr_wdata;
                    if (!sram_oe_n_reg) begin
                        avr_rdata_reg <= sram_data;
                    end
                    // Only hand over between AVR accesses.
                    if (mode_req && bus.avr_oe_n && bus.avr_we_n) begin
                        state_reg     <= TO_SNES;
                        guard_cnt_reg <= '0;
                        busy_reg      <= 1'b1;
                    end
                end

                TO_SNES: begin
                    sram_oe_n_reg <= 1'b1;
                    sram_we_n_reg <= 1'b1;
                    sram_ce_n_reg <= 1'b1;
                    // A reversed request takes priority and restarts the guard.
                    if (!mode_req) begin
                        state_reg     <= TO_AVR;
                        guard_cnt_reg <= '0;
                    end else if (guard_cnt_next == GUARD_LAST) begin
                        state_reg     <= SNES_OWN;
                        guard_cnt_reg <= '0;
                        mode_ack_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                    end else begin
                        guard_cnt_reg <= guard_cnt_next;
                    end
                end

                SNES_OWN: begin
                    sram_addr_reg <= bus.snes_addr;
                    sram_oe_n_reg <= bus.snes_rd_n | bus.snes_cs_n;
                    sram_ce_n_reg <= bus.snes_cs_n;
                    sram_we_n_reg <= 1'b1;
                    if (!sram_oe_n_reg) begin
                        snes_data_reg <= sram_data;
                    end
                    // Never pull the bus out from under an active SNES read.
                    if (!mode_req && bus.snes_rd_n) begin
                        state_reg     <= TO_AVR;
                        guard_cnt_reg <= '0;
                        busy_reg      <= 1'b1;
                    end
                end

                TO_AVR: begin
                    sram_oe_n_reg <= 1'b1;
                    sram_we_n_reg <= 1'b1;
                    sram_ce_n_reg <= 1'b1;
                    if (mode_req) begin
                        state_reg     <= TO_SNES;
                        guard_cnt_reg <= '0;
                    end else if (guard_cnt_next == GUARD_LAST) begin
                        state_reg     <= AVR_OWN;
                        guard_cnt_reg <= '0;
                        mode_ack_reg  <= 1'b0;
                        busy_reg      <= 1'b0;
                    end else begin
                        guard_cnt_reg <= guard_cnt_next;
                    end
                end

                default: begin
                    state_reg <= AVR_OWN;
                end
            endcase
        end
    end

    // Drive enable comes straight from registers, so reset releases the bus
    // immediately without waiting for a clock edge.
    assign sram_data_oe = (state_reg == AVR_OWN) && !sram_we_n_reg;

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_data_drv
            assign sram_data[gi] = sram_data_oe ? wdata_reg[gi] : 1'bz;
        end
    endgenerate

    assign sram_addr     = sram_addr_reg;
    assign sram_oe_n     = sram_oe_n_reg;
    assign sram_we_n     = sram_we_n_reg;
    assign sram_ce_n     = sram_ce_n_reg;
    assign bus.avr_rdata = avr_rdata_reg;
    assign bus.snes_data = snes_data_reg;
    assign bus.mode_ack  = mode_ack_reg;
    assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_bus_arbiter
// Scoreboard bench for sram_bus_arbiter. A driver applies one set of master
// inputs per cycle (at negedge), advances a bus-ownership reference model and
// queues the pin/response values expected after the next posedge. A monitor
// pops one entry per posedge and compares. A behavioural SRAM sits on the pins.
// -----------------------------------------------------------------------------
module tb_sram_bus_arbiter;
    import sram_bus_arbiter_pkg::*;

    localparam int AW = 21;
    localparam int DW = 8;
    localparam int G  = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    logic [AW-1:0] sram_addr;
    wire  [DW-1:0] sram_data;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic          sram_ce_n;

    sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .GUARD_CYCLES(G)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .sram_ce_n (sram_ce_n)
    );

    // ---------------- behavioural asynchronous SRAM ----------------
    logic [DW-1:0] sram_mem [0:(1<<AW)-1] = '{default: '0};
    assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_mem[sram_addr] : 'z;
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr] <= sram_data;
    end

    // ---------------- stimulus / expectation types ----------------
    typedef struct packed {
        logic          mode;
        logic [AW-1:0] aaddr;
        logic          aoe;
        logic          awe;
        logic [DW-1:0] wd;
        logic [AW-1:0] saddr;
        logic          srd;
        logic          scs;
    } in_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          oe_n, we_n, ce_n, drive;
        logic [DW-1:0] wdata, avr_rdata, snes_data;
        logic          mode_ack, busy;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // ---------------- reference model (ownership view) ----------------
    exp_t          cur;
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    bit            own_snes, in_guard, heading_snes;
    int            guard_done;
    logic          sync_a, sync_b;

    logic [AW-1:0] pool [8] = '{21'h00000, 21'h00123, 21'h1FFFFF, 21'h0ABCD,
                                21'h10055, 21'h07F0E, 21'h1234A, 21'h00001};

    task automatic model_reset();
        cur.addr = '0; cur.oe_n = 1'b1; cur.we_n = 1'b1; cur.ce_n = 1'b1;
        cur.drive = 1'b0; cur.wdata = '0; cur.avr_rdata = '0; cur.snes_data = '0;
        cur.mode_ack = 1'b0; cur.busy = 1'b0;
        own_snes = 0; in_guard = 0; heading_snes = 0; guard_done = 0;
        sync_a = 1'b0; sync_b = 1'b0;
    endtask

    task automatic model_step(input in_t i);
        logic          m;
        logic [DW-1:0] rd;
`ifdef MODE_SYNC_EN
        m = sync_b; sync_b = sync_a; sync_a = i.mode;
`else
        m = i.mode;
`endif
        // effect of the pins that were on the bus during the ending cycle
        if (!cur.oe_n) begin
            rd = ref_mem.exists(cur.addr) ? ref_mem[cur.addr] : '0;
            if (own_snes) cur.snes_data = rd;
            else          cur.avr_rdata = rd;
        end
        if (!cur.ce_n && !cur.we_n) ref_mem[cur.addr] = cur.wdata;

        if (in_guard) begin
            cur.oe_n = 1'b1; cur.we_n = 1'b1; cur.ce_n = 1'b1; cur.drive = 1'b0;
            if (m != heading_snes) begin
                heading_snes = m;
                guard_done   = 0;
            end else begin
                guard_done++;
                if (guard_done == G) begin
                    in_guard = 0;
                    own_snes = heading_snes;
                end
            end
        end else if (!own_snes) begin
            cur.addr  = i.aaddr;
            cur.we_n  = i.awe;
            cur.oe_n  = i.aoe | ~i.awe;
            cur.ce_n  = i.aoe & i.awe;
            cur.wdata = i.wd;
            cur.drive = ~i.awe;
            if (m && i.aoe && i.awe) begin
                in_guard = 1; heading_snes = 1; guard_done = 0;
            end
        end else begin
            cur.addr  = i.saddr;
            cur.oe_n  = i.srd | i.scs;
            cur.ce_n  = i.scs;
            cur.we_n  = 1'b1;
            cur.drive = 1'b0;
            if (!m && i.srd) begin
                in_guard = 1; heading_snes = 0; guard_done = 0;
            end
        end
        cur.busy     = in_guard;
        cur.mode_ack = own_snes;
        exp_q.push_back(cur);
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sram_addr", 32'(sram_addr), 32'(e.addr));
                chk("sram_oe_n", 32'(sram_oe_n), 32'(e.oe_n));
                chk("sram_we_n", 32'(sram_we_n), 32'(e.we_n));
                chk("sram_ce_n", 32'(sram_ce_n), 32'(e.ce_n));
                chk("data_drive", 32'(dut.sram_data_oe), 32'(e.drive));
                if (e.drive) chk("sram_data", 32'(sram_data), 32'(e.wdata));
                chk("avr_rdata", 32'(bus.avr_rdata), 32'(e.avr_rdata));
                chk("snes_data", 32'(bus.snes_data), 32'(e.snes_data));
                chk("mode_ack", 32'(bus.mode_ack), 32'(e.mode_ack));
                chk("busy", 32'(bus.busy), 32'(e.busy));
                $display("cyc %0d addr=%h oe=%b we=%b ce=%b rd_avr=%h rd_snes=%h ack=%b busy=%b",
                         cyc, sram_addr, sram_oe_n, sram_we_n, sram_ce_n,
                         bus.avr_rdata, bus.snes_data, bus.mode_ack, bus.busy);
            end
        end
    end

    // ---------------- driver ----------------
    function automatic in_t idle(input logic m);
        in_t r;
        r.mode = m; r.aaddr = '0; r.aoe = 1'b1; r.awe = 1'b1; r.wd = '0;
        r.saddr = '0; r.srd = 1'b1; r.scs = 1'b1;
        return r;
    endfunction

    task automatic apply_step(input in_t i);
        bus.avr_snes_mode = i.mode;
        bus.avr_addr      = i.aaddr;
        bus.avr_oe_n      = i.aoe;
        bus.avr_we_n      = i.awe;
        bus.avr_wdata     = i.wd;
        bus.snes_addr     = i.saddr;
        bus.snes_rd_n     = i.srd;
        bus.snes_cs_n     = i.scs;
        model_step(i);
    endtask

    task automatic drive(input in_t i);
        @(negedge clk);
        apply_step(i);
    endtask

    task automatic check_reset_pins(input string tag);
        chk({tag, "_oe_n"}, 32'(sram_oe_n), 32'd1);
        chk({tag, "_we_n"}, 32'(sram_we_n), 32'd1);
        chk({tag, "_ce_n"}, 32'(sram_ce_n), 32'd1);
        chk({tag, "_released"}, 32'(dut.sram_data_oe), 32'd0);
        chk({tag, "_state"}, 32'(dut.state_reg), 32'(AVR_OWN));
        chk({tag, "_mode_ack"}, 32'(bus.mode_ack), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin : stimulus
        in_t s;
        in_t r0;
        r0 = idle(1'b0);
        bus.avr_snes_mode = r0.mode; bus.avr_addr = r0.aaddr; bus.avr_oe_n = r0.aoe;
        bus.avr_we_n = r0.awe; bus.avr_wdata = r0.wd; bus.snes_addr = r0.saddr;
        bus.snes_rd_n = r0.srd; bus.snes_cs_n = r0.scs;

        // power-on reset
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_pins("por");
        chk("por_sram_addr", 32'(sram_addr), 32'd0);
        chk("por_avr_rdata", 32'(bus.avr_rdata), 32'd0);
        chk("por_snes_data", 32'(bus.snes_data), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        apply_step(idle(1'b0));

        // AVR write A5 -> 00123, then release
        s = idle(1'b0); s.awe = 1'b0; s.aaddr = 21'h00123; s.wd = 8'hA5; drive(s);
        drive(idle(1'b0));
        // AVR read back 00123
        s = idle(1'b0); s.aoe = 1'b0; s.aaddr = 21'h00123; drive(s);
        drive(idle(1'b0)); drive(idle(1'b0));
        // simultaneous oe/we: write wins
        s = idle(1'b0); s.aoe = 1'b0; s.awe = 1'b0; s.aaddr = 21'h1FFFFF; s.wd = 8'h3C; drive(s);
        drive(idle(1'b0));

        // request SNES while an AVR read is active: switch deferred
        s = idle(1'b1); s.aoe = 1'b0; s.aaddr = 21'h00123;
        repeat (3) drive(s);
        repeat (G + 4) drive(idle(1'b1));

        // SNES read of 1FFFFF
        s = idle(1'b1); s.scs = 1'b0; s.srd = 1'b0; s.saddr = 21'h1FFFFF; drive(s);
        drive(idle(1'b1)); drive(idle(1'b1));

        // AVR write strobe while SNES owns the bus is ignored
        s = idle(1'b1); s.awe = 1'b0; s.aaddr = 21'h00005; s.wd = 8'hFF; drive(s);
        drive(idle(1'b1));

        // release to AVR, SNES read holds the switch for one cycle
        s = idle(1'b0); s.scs = 1'b0; s.srd = 1'b0; s.saddr = 21'h00123; drive(s);
        repeat (G + 4) drive(idle(1'b0));

        // reverse the request one cycle into the hand-over
        drive(idle(1'b1)); drive(idle(1'b1));
        repeat (G + 4) drive(idle(1'b0));

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) s.mode = ~s.mode;
            s.aaddr = pool[$urandom_range(0, 7)];
            s.saddr = pool[$urandom_range(0, 7)];
            s.aoe   = ($urandom_range(0, 3) != 0);
            s.awe   = ($urandom_range(0, 3) != 0);
            s.wd    = 8'($urandom);
            s.srd   = ($urandom_range(0, 4) >= 2);
            s.scs   = ($urandom_range(0, 1) == 1);
            drive(s);
        end

        // back to AVR, then reset in the middle of a write
        repeat (G + 8) drive(idle(1'b0));
        s = idle(1'b0); s.awe = 1'b0; s.aaddr = 21'h0ABCD; s.wd = 8'h5A; drive(s);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_reset_pins("midreset");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        apply_step(idle(1'b0));
        s = idle(1'b0); s.aoe = 1'b0; s.aaddr = 21'h0ABCD; drive(s);
        repeat (3) drive(idle(1'b0));

        @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
